unstriping: RTL and testbench



---
 rtl/pcie_sym_pkg.sv | 38 +++
 rtl/lane_word_fifo.sv | 61 ++++++
 rtl/unstriping.sv | 154 +++++++++++++++
 tb/tb_unstriping.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_sym_pkg.sv
// ============================================================================
// Module : pcie_sym_pkg
// Brief  : Shared PCIe framing symbols and the lane word type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pcie_sym_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [7:0] c_COM = 8'hBC;
    localparam logic [7:0] c_PAD = 8'hF7;
    localparam logic [7:0] c_SKP = 8'h1C;
    localparam logic [7:0] c_STP = 8'hFB;
    localparam logic [7:0] c_SDP = 8'h5C;
    localparam logic [7:0] c_END = 8'hFD;
    localparam logic [7:0] c_EDB = 8'hFE;
    localparam logic [7:0] c_FTS = 8'h3C;
    localparam logic [7:0] c_IDL = 8'h7C;

    // bytes[0] is lane 0; len1 marks an ordered-set word that emits one byte.
    typedef struct packed {
        logic [NUM_LANES-1:0][7:0] bytes;
        logic                      len1;
    } lane_word_t;

    function automatic logic is_os_sym(input logic [7:0] sym);
        return (sym == c_COM) || (sym == c_SKP) || (sym == c_IDL) || (sym == c_FTS);
    endfunction

    function automatic logic is_pkt_start(input logic [7:0] sym);
        return (sym == c_STP) || (sym == c_SDP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_word_fifo.sv
// ============================================================================
// Module : lane_word_fifo
// Brief  : DEPTH-entry synchronous FIFO of lane words with occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_word_fifo
    import pcie_sym_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  lane_word_t                 i_data,
    input  logic                       i_pop,
    output lane_word_t                 o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);

    lane_word_t          r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_count;

    // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/unstriping.sv
// ============================================================================
// Module : unstriping
// Brief  : Four-lane receive un-striping: classifies words, buffers, serializes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module unstriping
    import pcie_sym_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] RL0,
    input  logic [7:0] RL1,
    input  logic [7:0] RL2,
    input  logic [7:0] RL3,
    input  logic       lanes_valid,
    output logic       lanes_ready,
    output logic [7:0] toDemux,
    output logic       out_valid,
    output logic       err
);

    localparam int c_AW = $clog2(DEPTH);

    localparam logic [0:0] c_ST_OS  = 1'b0;
    localparam logic [0:0] c_ST_PKT = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          w_accept;
    logic          w_push;
    logic          w_len1;
    logic          w_err_set;
    logic          w_all_same;
    logic          w_end_mid;
    lane_word_t    w_word;
    lane_word_t    w_head;
    logic [c_AW:0] w_count;
    logic          w_empty;
    logic          w_last;
    logic          w_pop;
    logic [1:0]    r_byte_idx;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_err;

    // Ready looks only at the registered count; a same-cycle pop does not help.
    assign lanes_ready = (w_count < (c_AW+1)'(DEPTH));
    assign w_accept    = lanes_valid && lanes_ready;

    assign w_all_same  = (RL0 == RL1) && (RL1 == RL2) && (RL2 == RL3);
    assign w_end_mid   = (RL0 == c_END) || (RL1 == c_END) || (RL2 == c_END);

    always_comb begin
        w_word.bytes = {RL3, RL2, RL1, RL0};
        w_word.len1  = w_len1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_len1      = 1'b0;
        w_err_set   = 1'b0;
        if (w_accept) begin
            case (r_state)
                c_ST_OS: begin
                    if (is_pkt_start(RL0)) begin
                        w_push = 1'b1;
                        if (RL3 != c_END) begin
                            w_state_nxt = c_ST_PKT;
                        end
                    end else if (w_all_same && is_os_sym(RL0)) begin
                        w_push = 1'b1;
                        w_len1 = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                c_ST_PKT: begin
                    if (w_end_mid) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = c_ST_OS;
                    end else if (RL3 == c_END) begin
                        w_push      = 1'b1;
                        w_state_nxt = c_ST_OS;
                    end else if (is_pkt_start(RL0)) begin
                        // Old packet is abandoned; the new start is kept.
                        w_push    = 1'b1;
                        w_err_set = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_OS;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_OS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    lane_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_empty = (w_count == '0);
    assign w_last  = w_head.len1 || (r_byte_idx == 2'd3);
    // Popping on the last byte lets the next word's byte 0 follow with no bubble.
    assign w_pop   = !w_empty && w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_byte_idx <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err_set;
            if (!w_empty) begin
                r_data     <= w_head.bytes[r_byte_idx];
                r_valid    <= 1'b1;
                r_byte_idx <= w_last ? 2'd0 : (r_byte_idx + 2'd1);
            end else begin
                r_data  <= 8'h00;
                r_valid <= 1'b0;
            end
        end
    end

    assign toDemux   = r_data;
    assign out_valid = r_valid;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_unstriping.sv
// ============================================================================
// Module : tb_unstriping
// Brief  : Scoreboard bench for unstriping: expected bytes queued on drive.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_unstriping;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] RL0 = 8'h00;
    logic [7:0] RL1 = 8'h00;
    logic [7:0] RL2 = 8'h00;
    logic [7:0] RL3 = 8'h00;
    logic       lanes_valid = 1'b0;
    logic       lanes_ready;
    logic [7:0] toDemux;
    logic       out_valid;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int err_cnt = 0;
    int err_cyc = -1;
    logic [7:0] exp_q[$];
    int         obs_cyc[$];

    unstriping #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .RL0         (RL0),
        .RL1         (RL1),
        .RL2         (RL2),
        .RL3         (RL3),
        .lanes_valid (lanes_valid),
        .lanes_ready (lanes_ready),
        .toDemux     (toDemux),
        .out_valid   (out_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard: each emitted byte is matched against the head of exp_q.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (!reset) begin
            if (out_valid) begin
                obs_cyc.push_back(cycle);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h, expected no output", toDemux);
                end else begin
                    e = exp_q.pop_front();
                    if (toDemux !== e) begin
                        errors++;
                        $display("FAIL byte: got %h, expected %h", toDemux, e);
                    end
                end
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_cyc = cycle;
            end
        end
    end

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             output int acc);
        int n = 0;
        RL0 = b0; RL1 = b1; RL2 = b2; RL3 = b3;
        lanes_valid = 1'b1;
        while (lanes_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: lanes_ready stuck at %b, expected 1", lanes_ready);
        end
        @(posedge clk);
        @(negedge clk);
        acc = cycle;
    endtask

    task automatic idle_wait(input int n);
        lanes_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_scenario();
        obs_cyc.delete();
        err_cnt = 0;
        err_cyc = -1;
    endtask

    task automatic test_reset();
        int a;
        checks++;
        if (toDemux !== 8'h00 || out_valid !== 1'b0 || err !== 1'b0 || lanes_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got data=%h v=%b err=%b rdy=%b, expected 00 0 0 1",
                     toDemux, out_valid, err, lanes_ready);
        end
        start_scenario();
        exp_q.push_back(8'hFB); exp_q.push_back(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        send_word(8'hFB, 8'h01, 8'h02, 8'h03, a);
        lanes_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (toDemux !== 8'h00 || out_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got data=%h v=%b err=%b, expected 00 0 0",
                     toDemux, out_valid, err);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (lanes_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 1", lanes_ready);
        end
        start_scenario();
        exp_q.push_back(8'h7C);
        send_word(8'h7C, 8'h7C, 8'h7C, 8'h7C, a);
        idle_wait(8);
        checks++;
        if (obs_cyc.size() != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idl: got %0d bytes (%0d pending), expected 1 byte",
                     obs_cyc.size(), exp_q.size());
        end
    endtask

    task automatic test_ordered_set();
        int a, b, c;
        start_scenario();
        exp_q.push_back(8'h7C);
        send_word(8'h7C, 8'h7C, 8'h7C, 8'h7C, a);
        idle_wait(6);
        checks++;
        if (obs_cyc.size() != 1 || obs_cyc[0] != a + 1) begin
            errors++;
            $display("FAIL os_single: got %0d bytes first at %0d, expected 1 at %0d",
                     obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, a + 1);
        end
        start_scenario();
        exp_q.push_back(8'hBC); exp_q.push_back(8'h1C); exp_q.push_back(8'h3C);
        send_word(8'hBC, 8'hBC, 8'hBC, 8'hBC, a);
        send_word(8'h1C, 8'h1C, 8'h1C, 8'h1C, b);
        send_word(8'h3C, 8'h3C, 8'h3C, 8'h3C, c);
        idle_wait(6);
        checks++;
        if (obs_cyc.size() != 3 || c != a + 2 || obs_cyc[2] != a + 3 || err_cnt != 0) begin
            errors++;
            $display("FAIL os_burst: got %0d bytes last at %0d acc %0d..%0d err %0d, expected 3 at %0d",
                     obs_cyc.size(), (obs_cyc.size() > 2) ? obs_cyc[2] : -1, a, c, err_cnt, a + 3);
        end
    endtask

    task automatic test_packet();
        int a, b;
        logic [7:0] pk [8] = '{8'hFB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFD};
        start_scenario();
        for (int i = 0; i < 8; i++) exp_q.push_back(pk[i]);
        send_word(pk[0], pk[1], pk[2], pk[3], a);
        send_word(pk[4], pk[5], pk[6], pk[7], b);
        idle_wait(12);
        checks++;
        if (obs_cyc.size() != 8 || obs_cyc[0] != a + 1 || obs_cyc[7] != a + 8 || err_cnt != 0) begin
            errors++;
            $display("FAIL packet_timing: got %0d bytes first %0d last %0d err %0d, expected 8 from %0d",
                     obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1,
                     (obs_cyc.size() > 7) ? obs_cyc[7] : -1, err_cnt, a + 1);
        end
        start_scenario();
        exp_q.push_back(8'h7C);
        send_word(8'h7C, 8'h7C, 8'h7C, 8'h7C, a);
        idle_wait(6);
        checks++;
        if (obs_cyc.size() != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL packet_back_to_os: got %0d bytes, expected 1", obs_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3;
        start_scenario();
        for (int i = 0; i < 12; i++) exp_q.push_back((i == 0) ? 8'hFB : (i == 11) ? 8'hFD : 8'(i));
        send_word(8'hFB, 8'h01, 8'h02, 8'h03, a1);
        send_word(8'h04, 8'h05, 8'h06, 8'h07, a2);
        send_word(8'h08, 8'h09, 8'h0A, 8'hFD, a3);
        idle_wait(16);
        checks++;
        if (a2 != a1 + 1 || a3 != a1 + 5) begin
            errors++;
            $display("FAIL bp_accept: got accepts at +%0d,+%0d, expected +1,+5", a2 - a1, a3 - a1);
        end
        checks++;
        if (obs_cyc.size() != 12 || obs_cyc[0] != a1 + 1 || obs_cyc[11] != a1 + 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_stream: got %0d bytes first %0d last %0d, expected 12 from %0d to %0d",
                     obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1,
                     (obs_cyc.size() > 11) ? obs_cyc[11] : -1, a1 + 1, a1 + 12);
        end
    endtask

    task automatic test_err_os();
        int a;
        start_scenario();
        send_word(8'h7C, 8'h7C, 8'hBC, 8'h7C, a);
        idle_wait(6);
        checks++;
        if (err_cnt != 1 || err_cyc != a || obs_cyc.size() != 0) begin
            errors++;
            $display("FAIL err_os: got err %0d at %0d bytes %0d, expected 1 at %0d bytes 0",
                     err_cnt, err_cyc, obs_cyc.size(), a);
        end
    endtask

    task automatic test_err_pkt();
        int a, b, c;
        start_scenario();
        exp_q.push_back(8'hFB); exp_q.push_back(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        send_word(8'hFB, 8'h01, 8'h02, 8'h03, a);
        send_word(8'h01, 8'hFD, 8'h02, 8'h03, b);
        idle_wait(8);
        exp_q.push_back(8'h7C);
        send_word(8'h7C, 8'h7C, 8'h7C, 8'h7C, c);
        idle_wait(6);
        checks++;
        if (err_cnt != 1 || err_cyc != b) begin
            errors++;
            $display("FAIL err_pkt_pulse: got err %0d at %0d, expected 1 at %0d", err_cnt, err_cyc, b);
        end
        checks++;
        if (obs_cyc.size() != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_pkt_output: got %0d bytes, expected 5", obs_cyc.size());
        end
    endtask

    task automatic test_restart();
        int a, b, c, d;
        logic [7:0] pk [12] = '{8'hFB, 8'h0A, 8'h0B, 8'h0C, 8'h5C, 8'h11, 8'h12, 8'h13,
                                8'h21, 8'h22, 8'h23, 8'hFD};
        start_scenario();
        for (int i = 0; i < 12; i++) exp_q.push_back(pk[i]);
        send_word(pk[0], pk[1], pk[2], pk[3], a);
        send_word(pk[4], pk[5], pk[6], pk[7], b);
        send_word(pk[8], pk[9], pk[10], pk[11], c);
        idle_wait(16);
        exp_q.push_back(8'h7C);
        send_word(8'h7C, 8'h7C, 8'h7C, 8'h7C, d);
        idle_wait(6);
        checks++;
        if (err_cnt != 1 || err_cyc != b) begin
            errors++;
            $display("FAIL restart_err: got err %0d at %0d, expected 1 at %0d", err_cnt, err_cyc, b);
        end
        checks++;
        if (obs_cyc.size() != 13 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_output: got %0d bytes, expected 13", obs_cyc.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_ordered_set();
        test_packet();
        test_back_to_back();
        test_err_os();
        test_err_pkt();
        test_restart();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending bytes, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
